// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the arbitrated 4-bit ALU: op codes, illegal-op marker,
// default requester count and the requester-id width rule.
package alu_share_arb_pkg;

    typedef enum logic [1:0] {
        OP_ADD     = 2'd0,
        OP_SUB     = 2'd1,
        OP_SHIFT   = 2'd2,
        ALU_ERR_OP = 2'd3
    } alu_op_e;

    localparam int DEF_NREQ = 2;
    localparam int DEF_BITS = 4;

    // Id width is clog2(NREQ) but never narrower than one bit.
    function automatic int idw_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_arbiter.sv
// Round-robin priority scan: first asserted request at or after ptr wins,
// wrapping modulo NREQ.
module rr_arbiter
    import alu_share_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = idw_for(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_any && req[idx]) begin
                grant_any      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// One registered ALU shared by NREQ valid/ready requesters through a round-robin
// arbiter; the tagged result sits in a one-entry output register until drained.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int Bits = DEF_BITS,
    parameter int IDW  = idw_for(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*Bits-1:0] req_a,
    input  logic [NREQ*Bits-1:0] req_b,
    input  logic [NREQ*2-1:0]    req_op,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [Bits-1:0]      resp_data,
    output logic                 resp_err
);

    logic [Bits-1:0] a_arr  [NREQ];
    logic [Bits-1:0] b_arr  [NREQ];
    logic [1:0]      op_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[gi*Bits +: Bits];
            assign b_arr[gi]  = req_b[gi*Bits +: Bits];
            assign op_arr[gi] = req_op[gi*2 +: 2];
        end
    endgenerate

    // Result is {err, data}; an illegal code yields zero data with err set.
    function automatic logic [Bits:0] alu_fn(input logic [1:0] op,
                                             input logic [Bits-1:0] a,
                                             input logic [Bits-1:0] b);
        logic [Bits-1:0] r;
        logic            e;
        r = '0;
        e = 1'b0;
        case (alu_op_e'(op))
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_SHIFT: r = (int'(b) >= Bits) ? '0 : (a << b);
            default:  e = 1'b1;
        endcase
        return {e, r};
    endfunction

    logic            resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q,    resp_id_d;
    logic [Bits-1:0] resp_data_q,  resp_data_d;
    logic            resp_err_q,   resp_err_d;
    logic [IDW-1:0]  ptr_q,        ptr_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            accept;
    logic            xfer;
    logic [Bits:0]   alu_res;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Accept only while the output slot is free or draining this cycle;
    // reset also forces every ready low.
    assign accept    = reset && (!resp_valid_q || resp_ready);
    assign req_ready = grant & {NREQ{accept}};
    assign xfer      = accept && grant_any;
    assign alu_res   = alu_fn(op_arr[grant_idx], a_arr[grant_idx], b_arr[grant_idx]);

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        ptr_d        = ptr_q;
        if (xfer) begin
            resp_valid_d = 1'b1;
            resp_id_d    = grant_idx;
            resp_data_d  = alu_res[Bits-1:0];
            resp_err_d   = alu_res[Bits];
            ptr_d        = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            ptr_q        <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            ptr_q        <= ptr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed table, corner sequences and
// randomized traffic compared against a behavioural model.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int N = 2;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N*2-1:0] req_op = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [0:0]     resp_id;
    logic [W-1:0]   resp_data;
    logic           resp_err;

    alu_share_arb #(.NREQ(N), .Bits(W), .IDW(1)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int m_ptr  = 0;
    bit m_v    = 0;
    int m_id   = 0;
    int m_data = 0;
    bit m_err  = 0;

    function automatic int ref_alu(input int op, input int a, input int b, output bit err);
        err = 0;
        case (op)
            0: return (a + b) % 16;
            1: return (a - b + 16) % 16;
            2: return (b >= W) ? 0 : (a * (1 << b)) % 16;
            default: begin err = 1; return 0; end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int b, input int op);
        req_valid[i]       = v;
        req_a[i*W +: W]    = W'(a);
        req_b[i*W +: W]    = W'(b);
        req_op[i*2 +: 2]   = 2'(op);
    endtask

    // One clock: compare DUT against model mid-cycle, then advance model to the edge.
    task automatic cycle(output logic [N-1:0] rdy);
        int       g;
        bit       acc;
        bit       e;
        int       d;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        acc = rst_n && (!m_v || resp_ready);
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_rdy = '0;
        if (acc && g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready",  32'(req_ready),  32'(exp_rdy));
        check("resp_valid", 32'(resp_valid), 32'(m_v));
        check("resp_id",    32'(resp_id),    32'(m_id));
        check("resp_data",  32'(resp_data),  32'(m_data));
        check("resp_err",   32'(resp_err),   32'(m_err));
        rdy = req_ready;
        if (!rst_n) begin
            m_v = 0; m_id = 0; m_data = 0; m_err = 0; m_ptr = 0;
        end else if (acc && g >= 0) begin
            d = ref_alu(int'(req_op[g*2 +: 2]), int'(req_a[g*W +: W]), int'(req_b[g*W +: W]), e);
            m_v = 1; m_id = g; m_data = d; m_err = e; m_ptr = (g + 1) % N;
            $display("[TB] t=%0t xfer req%0d a=%0d b=%0d op=%0d -> data=%0h err=%0d",
                     $time, g, req_a[g*W +: W], req_b[g*W +: W], req_op[g*2 +: 2], d, e);
        end else if (m_v && resp_ready) begin
            m_v = 0;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int a;
        int b;
        int op;
        int exp_data;
        int exp_err;
    } vec_t;

    vec_t tbl [10];
    logic [N-1:0] rdy;

    initial begin
        tbl[0] = '{3, 5, 0, 8,   0};
        tbl[1] = '{2, 3, 1, 15,  0};
        tbl[2] = '{9, 9, 0, 2,   0};
        tbl[3] = '{3, 2, 2, 12,  0};
        tbl[4] = '{1, 7, 2, 0,   0};
        tbl[5] = '{15, 1, 0, 0,  0};
        tbl[6] = '{0, 1, 1, 15,  0};
        tbl[7] = '{5, 3, 2, 8,   0};
        tbl[8] = '{5, 4, 2, 0,   0};
        tbl[9] = '{7, 3, 3, 0,   1};

        // Reset state
        @(posedge clk); #1;
        cycle(rdy);
        set_req(0, 1, 3, 5, 0);
        cycle(rdy);
        check("reset_ready_low", 32'(rdy), 32'd0);
        rst_n = 1'b1;
        set_req(0, 0, 0, 0, 0);
        resp_ready = 1'b1;
        cycle(rdy);

        // Directed table on requester 0, one request at a time
        for (int i = 0; i < 10; i++) begin
            set_req(0, 1, tbl[i].a, tbl[i].b, tbl[i].op);
            cycle(rdy);
            check("tbl_ready0", 32'(rdy), 32'd1);
            set_req(0, 0, 0, 0, 0);
            check("tbl_data", 32'(resp_data), 32'(tbl[i].exp_data));
            check("tbl_err",  32'(resp_err),  32'(tbl[i].exp_err));
            cycle(rdy);
        end

        // Round-robin after reset: grants 0,1,0,1 with one result per cycle
        rst_n = 1'b0;
        cycle(rdy);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        set_req(0, 1, 1, 1, 0);
        set_req(1, 1, 2, 2, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(rdy);
            check("rr_grant", 32'(rdy), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_resp_id", 32'(resp_id), 32'(k % 2));
            check("rr_resp_valid", 32'(resp_valid), 32'd1);
        end

        // Back-pressure: three stalled cycles, then drain and refill together
        set_req(1, 0, 0, 0, 0);
        set_req(0, 1, 4, 4, 0);
        cycle(rdy);
        resp_ready = 1'b0;
        set_req(0, 1, 6, 1, 1);
        set_req(1, 1, 7, 2, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(rdy);
            check("bp_ready_zero", 32'(rdy), 32'd0);
            check("bp_data_hold", 32'(resp_data), 32'd8);
        end
        resp_ready = 1'b1;
        cycle(rdy);
        check("bp_refill_grant", 32'(rdy), 32'd2);
        check("bp_refill_valid", 32'(resp_valid), 32'd1);
        check("bp_refill_data", 32'(resp_data), 32'd5);
        set_req(1, 0, 0, 0, 0);

        // Illegal op from requester 1
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 9, 3, 3);
        cycle(rdy);
        check("illegal_consumed", 32'(rdy), 32'd2);
        check("illegal_err", 32'(resp_err), 32'd1);
        set_req(1, 0, 0, 0, 0);
        cycle(rdy);

        // Reset while a result is held and requests pend
        resp_ready = 1'b0;
        set_req(1, 1, 1, 2, 0);
        cycle(rdy);
        set_req(0, 1, 3, 3, 0);
        rst_n = 1'b0;
        cycle(rdy);
        check("rst_mid_valid", 32'(resp_valid), 32'd0);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        cycle(rdy);
        check("rst_mid_first_grant", 32'(rdy), 32'd1);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        cycle(rdy);

        // Randomized traffic obeying the hold-until-ready protocol
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 2 == 0))
                    set_req(i, 1, int'($urandom % 16), int'($urandom % 16), int'($urandom % 4));
            end
            resp_ready = ($urandom % 4) != 0;
            rst_n      = ($urandom % 40) != 0;
            cycle(rdy);
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) req_valid[i] = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one registered 4-bit ALU (add/sub/shift, op codes from aluops.h) between NREQ requesters.
- Each requester uses a valid/ready handshake; a round-robin arbiter grants at most one request per cycle.
- The block computes the granted operation and holds the tagged result in a one-entry output register until the consumer accepts it.
- It sits between the issuing units and the ALU, replacing per-unit ALU copies.

Parameters:
- NREQ, 2, number of requesters (2..4).
- Bits, 4, operand/result width.
- IDW, 1, requester-id width: clog2(NREQ), minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low: state clears on a clk edge while reset==0.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  grant/accept, one-hot or zero.
- req_a  in  NREQ*Bits  operand a; requester i occupies bits [i*Bits +: Bits].
- req_b  in  NREQ*Bits  operand b, same packing.
- req_op  in  NREQ*2  op code; requester i occupies bits [i*2 +: 2]; values are `OP_ADD, `OP_SUB, `OP_SHIFT.
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  IDW  index of the requester that produced the result.
- resp_data  out  Bits  result.
- resp_err  out  1  the op code was illegal (the fourth, unassigned code).

Behaviour:
- Reset (reset==0 at an edge):
  - resp_valid=0, resp_id=0, resp_data=0, resp_err=0.
  - Round-robin pointer ptr=0.
  - Any pending result is discarded.
  - req_ready=0 in every cycle in which reset==0.
- Accept condition: accept = reset && (!resp_valid || resp_ready). The output register is empty or is being drained this cycle.
- Grant (combinational):
  - Scan requesters starting at index ptr, then ptr+1, ..., wrapping modulo NREQ.
  - The first requester with req_valid=1 is granted.
  - req_ready[g] = accept for the granted index g; all other bits are 0.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Transfer: a transfer occurs at an edge where req_valid[g] && req_ready[g]. At that edge:
  - resp_valid<=1, resp_id<=g, ptr<=(g+1) mod NREQ.
  - resp_data and resp_err are set per the arithmetic rules below, using requester g's operands.
- Arithmetic (results are modulo 2^Bits):
  - `OP_ADD: a+b, carry dropped.
  - `OP_SUB: a-b, two's-complement wrap.
  - `OP_SHIFT: a<<b, with b taken as an unsigned Bits-wide amount; a shift of Bits or more gives 0.
  - Illegal op code: resp_data=0, resp_err=1. The request is still consumed.
- Drain: at an edge with resp_valid && resp_ready and no new transfer, resp_valid<=0. resp_id, resp_data and resp_err hold their values.
- Simultaneous drain and new transfer: the register is overwritten with the new result and resp_valid stays 1. This gives full throughput: one result per cycle.
- Stall: while resp_valid && !resp_ready:
  - accept=0, so all req_ready bits are 0.
  - resp_* hold stable. ptr holds.
- No request valid: ptr holds and no state changes except drain.
- Latency: request accepted at edge T gives resp_valid=1 in the cycle after T.
- Requester protocol: a requester holds req_valid and its operands stable until it sees req_ready. The arbiter does not check this rule.
- Reset mid-operation: reset wins over a transfer or drain in the same cycle.

Decomposition:
- Shared header (alongside aluops.h) holds:
  - the op-code macros;
  - an ALU_ERR_OP constant for the illegal code;
  - the default NREQ and the IDW rule.
- Sub-module rr_arbiter (parameter NREQ):
  - inputs: req vector, ptr;
  - outputs: one-hot grant and encoded index.
- The ALU function is a local function. Output registers use the existing flop module, with reset behaviour wrapped for active-low synchronous reset.

Test Plan:
- Single request: requester 0 sends a=4'd3, b=4'd5, `OP_ADD with resp_ready=1. Expect req_ready[0]=1 in the same cycle, then next cycle resp_valid=1, resp_id=0, resp_data=4'd8, resp_err=0.
- Wrap and shift: a=4'd2, b=4'd3, `OP_SUB gives 4'hF. a=4'd9, b=4'd9, `OP_ADD gives 4'd2. a=4'd3, b=4'd2, `OP_SHIFT gives 4'hC. a=4'd1, b=4'd7, `OP_SHIFT gives 4'd0.
- Round-robin: both requesters hold valid continuously with resp_ready=1. Expect grants 0,1,0,1 and resp_id alternating, one result per cycle.
- Back-pressure: resp_ready=0 for 3 cycles after a result arrives. Expect req_ready=0 throughout and resp_* stable. When resp_ready rises, the next request transfers in the same cycle and resp_valid stays 1.
- Illegal op: requester 1 sends the fourth op code. Expect resp_err=1, resp_data=0, resp_id=1, and the request consumed.
- Reset mid-operation: assert reset=0 while resp_valid=1 and requests are pending. Next cycle resp_valid=0 and req_ready=0. After release, requester 0 wins first because ptr=0.
